game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter N_OBST, default 2, number of obstacle sprite channels (1..8).
REQ-002 Parameter SCORE_W, default 16, score and hi-score width in bits.
REQ-003 Parameter FLASH_CYC, default 50, length of the HIT state in clk cycles (>=2).
REQ-004 clk  in  1  system pixel clock; single clock domain.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 video_on  in  1  high inside the visible area.
REQ-007 start  in  1  player button, level; rising edge is the start/restart request.
REQ-008 score_tick  in  1  one-cycle score increment strobe.
REQ-009 goose, goose_rgb  in  1, 12  player sprite pixel flag and colour.
REQ-010 obst, obst_rgb  in  N_OBST, 12*N_OBST  obstacle pixel flags; channel i colour in bits [12i+11:12i].
REQ-011 score_px, score_rgb, hi_px, hi_rgb  in  1, 12, 1, 12  score overlay flags and colours.
REQ-012 end_px, floor, grass, sky, sky_rgb  in  1, 1, 1, 1, 12  game-over text and background layers.
REQ-013 rgb  out  12  registered pixel colour.
REQ-014 state  out  2  FSM state: IDLE=0, RUN=1, HIT=2, OVER=3.
REQ-015 run  out  1  high only in RUN; animation enable for the sprite blocks.
REQ-016 score, hi_score  out  SCORE_W  current score and best score.
REQ-017 hit_vec  out  N_OBST  latched obstacle channels that caused the collision.

Function
REQ-018 Start edge: start_edge = start & ~start_q; start_q is registered every cycle.
REQ-019 IDLE -> RUN on start_edge; score cleared to 0 and hit_vec cleared to 0 on that transition.
REQ-020 RUN -> HIT when goose & |obst in the same cycle; hit_vec <= obst of that cycle.
REQ-021 HIT -> OVER after exactly FLASH_CYC cycles in HIT; start_edge is ignored in HIT.
REQ-022 OVER -> RUN on start_edge; score and hit_vec cleared to 0 on that transition.
REQ-023 start_edge in RUN has no effect; collisions outside RUN are ignored.
REQ-024 score increments by 1 on score_tick only in RUN, saturates at 2^SCORE_W-1, no wrap.
REQ-025 Collision and score_tick in the same RUN cycle: the collision wins; the score is not incremented.
REQ-026 On entry to OVER, hi_score <= score if score > hi_score, else hi_score is unchanged; hi_score survives restarts.
REQ-027 Pixel priority, highest first: end_px (OVER only) 0xFFF; score_px; hi_px; goose; obst, lowest index first; floor 0x940; grass 0x2A2; sky sky_rgb; otherwise 0x000.
REQ-028 rgb = 0x000 when video_on is low; rgb latency is 1 clk from the inputs.
REQ-029 All outputs are registered or decoded directly from registered state; no combinational path runs from inputs to outputs.

Reset
REQ-030 Assertion of reset (low) asynchronously forces: state IDLE, run 0, score 0, hi_score 0, hit_vec 0, rgb 0x000, HIT counter 0.
REQ-031 start_q resets to 1, so a button held through reset release does not start a game.
REQ-032 Reset mid-game (any state) returns to IDLE and clears hi_score.

Configuration
REQ-033 Macro GAME_CTRL_FLASH_EN defined: in HIT, rgb is bitwise-inverted (after priority mux, when video_on is high) on cycles where bit 3 of the HIT counter is 1.
REQ-034 GAME_CTRL_FLASH_EN undefined: the HIT state is never entered; a collision in RUN goes directly to OVER with the same hit_vec and hi_score updates.

Verification
REQ-035 Reset, then start held high for 10 cycles -> state stays 0 (IDLE); release, then pulse start -> state 1, run 1, score 0.
REQ-036 In RUN, 5 score_tick pulses, then goose=1 and obst=2'b10 together with a score_tick -> score 5, hit_vec 2'b10; state 2 for 50 cycles, then 3; hi_score 5.
REQ-037 SCORE_W=4: 20 ticks in RUN -> score saturates at 15.
REQ-038 Same pixel with goose=1, obst=2'b01, score_px=1 -> rgb equals score_rgb one cycle later; with video_on=0 -> rgb 0x000.
REQ-039 OVER with hi_score 5, restart, reach score 3, collide -> hi_score remains 5; restart and reach score 9, collide -> hi_score 9.
REQ-040 With FLASH_EN, goose_rgb=0x123 during HIT cycles 8..15 -> rgb 0xEDC; without the macro, the collision gives state 3 on the next cycle.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: game FSM, score/hi-score keeping, collision latch and pixel priority mux.
// Optional feature: define GAME_CTRL_FLASH_EN to enable the HIT flash state; without it a collision goes straight to OVER.
module game_ctrl #(
    parameter int N_OBST    = 2,
    parameter int SCORE_W   = 16,
    parameter int FLASH_CYC = 50
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_video_on,
    input  logic                  i_start,
    input  logic                  i_score_tick,
    input  logic                  i_goose,
    input  logic [11:0]           i_goose_rgb,
    input  logic [N_OBST-1:0]     i_obst,
    input  logic [12*N_OBST-1:0]  i_obst_rgb,
    input  logic                  i_score_px,
    input  logic [11:0]           i_score_rgb,
    input  logic                  i_hi_px,
    input  logic [11:0]           i_hi_rgb,
    input  logic                  i_end_px,
    input  logic                  i_floor,
    input  logic                  i_grass,
    input  logic                  i_sky,
    input  logic [11:0]           i_sky_rgb,
    output logic [11:0]           o_rgb,
    output logic [1:0]            o_state,
    output logic                  o_run,
    output logic [SCORE_W-1:0]    o_score,
    output logic [SCORE_W-1:0]    o_hi_score,
    output logic [N_OBST-1:0]     o_hit_vec
);
    localparam int CW = ($clog2(FLASH_CYC) > 4) ? $clog2(FLASH_CYC) : 4;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HIT = 2'd2, S_OVER = 2'd3} state_t;
`ifdef GAME_CTRL_FLASH_EN
    localparam state_t COLL_DST = S_HIT;
`else
    localparam state_t COLL_DST = S_OVER;
`endif
    state_t               r_state, w_next;
    logic                 r_start_q;
    logic [CW-1:0]        r_cnt;
    logic [SCORE_W-1:0]   r_score, r_hi;
    logic [N_OBST-1:0]    r_hit_vec;
    logic [11:0]          r_rgb, w_pix;
    logic                 w_edge, w_coll, w_go, w_enter_over, w_flash;

    assign w_edge       = i_start & ~r_start_q;
    assign w_coll       = i_goose & (|i_obst);
    assign w_go         = (r_state != S_RUN) && (w_next == S_RUN);
    assign w_enter_over = (r_state != S_OVER) && (w_next == S_OVER);
`ifdef GAME_CTRL_FLASH_EN
    assign w_flash      = (r_state == S_HIT) && r_cnt[3];
`else
    assign w_flash      = 1'b0;
`endif

    // Next-state decode; start edges only matter in IDLE/OVER, collisions only in RUN
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (w_edge) w_next = S_RUN;
            S_RUN:          if (w_coll) w_next = COLL_DST;
            S_HIT:          if (r_cnt == CW'(FLASH_CYC - 1)) w_next = S_OVER;
            default:        w_next = r_state;
        endcase
    end

    // State register, start edge detector and HIT duration counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_start_q <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next;
            r_start_q <= i_start;
            r_cnt     <= (r_state == S_HIT && w_next == S_HIT) ? r_cnt + 1'b1 : '0;
        end
    end

    // Score, hi-score and collision latch; a collision beats a same-cycle score tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score   <= '0;
            r_hi      <= '0;
            r_hit_vec <= '0;
        end else begin
            if (w_go) begin
                r_score   <= '0;
                r_hit_vec <= '0;
            end else if (r_state == S_RUN && w_coll)
                r_hit_vec <= i_obst;
            else if (r_state == S_RUN && i_score_tick && r_score != '1)
                r_score <= r_score + 1'b1;
            if (w_enter_over && r_score > r_hi)
                r_hi <= r_score;
        end
    end

    // Pixel priority mux, lowest priority layer first so later layers override
    always_comb begin
        w_pix = 12'h000;
        if (i_sky)   w_pix = i_sky_rgb;
        if (i_grass) w_pix = 12'h2A2;
        if (i_floor) w_pix = 12'h940;
        for (int i = N_OBST - 1; i >= 0; i--)
            if (i_obst[i]) w_pix = i_obst_rgb[12*i +: 12];
        if (i_goose)    w_pix = i_goose_rgb;
        if (i_hi_px)    w_pix = i_hi_rgb;
        if (i_score_px) w_pix = i_score_rgb;
        if (i_end_px && r_state == S_OVER) w_pix = 12'hFFF;
    end

    // Registered colour output with blanking and optional HIT flash inversion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rgb <= 12'h000;
        else          r_rgb <= !i_video_on ? 12'h000 : w_flash ? ~w_pix : w_pix;
    end

    assign o_rgb      = r_rgb;
    assign o_state    = r_state;
    assign o_run      = (r_state == S_RUN);
    assign o_score    = r_score;
    assign o_hi_score = r_hi;
    assign o_hit_vec  = r_hit_vec;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: vector table, directed game sequences and random play against a behavioural model.
module tb_game_ctrl;
    localparam int FC   = 50;
    localparam int SMAX = 65535;
`ifdef GAME_CTRL_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    logic clk = 1'b0, rst_n;
    logic video_on = 0, start = 0, score_tick = 0, goose = 0;
    logic [11:0] goose_rgb = 0, score_rgb = 0, hi_rgb = 0, sky_rgb = 0;
    logic [1:0] obst = 0;
    logic [23:0] obst_rgb = 0;
    logic score_px = 0, hi_px = 0, end_px = 0, flr = 0, grass = 0, sky = 0;
    logic [11:0] rgb, rgb4;
    logic [1:0] state, state4, hit_vec, hit_vec4;
    logic run, run4;
    logic [15:0] score, hi_score;
    logic [3:0] score4, hi_score4;

    game_ctrl #(.N_OBST(2), .SCORE_W(16), .FLASH_CYC(FC)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_video_on(video_on), .i_start(start), .i_score_tick(score_tick),
        .i_goose(goose), .i_goose_rgb(goose_rgb), .i_obst(obst), .i_obst_rgb(obst_rgb),
        .i_score_px(score_px), .i_score_rgb(score_rgb), .i_hi_px(hi_px), .i_hi_rgb(hi_rgb),
        .i_end_px(end_px), .i_floor(flr), .i_grass(grass), .i_sky(sky), .i_sky_rgb(sky_rgb),
        .o_rgb(rgb), .o_state(state), .o_run(run), .o_score(score), .o_hi_score(hi_score), .o_hit_vec(hit_vec));

    game_ctrl #(.N_OBST(2), .SCORE_W(4), .FLASH_CYC(FC)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_video_on(video_on), .i_start(start), .i_score_tick(score_tick),
        .i_goose(goose), .i_goose_rgb(goose_rgb), .i_obst(obst), .i_obst_rgb(obst_rgb),
        .i_score_px(score_px), .i_score_rgb(score_rgb), .i_hi_px(hi_px), .i_hi_rgb(hi_rgb),
        .i_end_px(end_px), .i_floor(flr), .i_grass(grass), .i_sky(sky), .i_sky_rgb(sky_rgb),
        .o_rgb(rgb4), .o_state(state4), .o_run(run4), .o_score(score4), .o_hi_score(hi_score4), .o_hit_vec(hit_vec4));

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    int m_mode, m_score, m_hi, m_hit, m_el;
    bit m_startq;

    typedef struct packed {
        logic vo, ep, sp, hp, gs;
        logic [1:0] ob;
        logic fl, gr, sk;
        logic [11:0] exp;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic logic [11:0] ref_pix();
        logic [11:0] p;
        if (!video_on) return 12'h000;
        if (end_px && m_mode == 3) p = 12'hFFF;
        else if (score_px) p = score_rgb;
        else if (hi_px) p = hi_rgb;
        else if (goose) p = goose_rgb;
        else if (obst[0]) p = obst_rgb[11:0];
        else if (obst[1]) p = obst_rgb[23:12];
        else if (flr) p = 12'h940;
        else if (grass) p = 12'h2A2;
        else if (sky) p = sky_rgb;
        else p = 12'h000;
        if (FLASH && m_mode == 2 && ((m_el / 8) % 2 == 1)) p = ~p;
        return p;
    endfunction

    task automatic go_over();
        m_mode = 3;
        if (m_score > m_hi) m_hi = m_score;
    endtask

    task automatic step();
        logic [11:0] p;
        bit e_s, coll;
        p = ref_pix();
        e_s = start && !m_startq;
        coll = goose && (obst != 0);
        if (m_mode == 0 || m_mode == 3) begin
            if (e_s) begin m_mode = 1; m_score = 0; m_hit = 0; end
        end else if (m_mode == 1) begin
            if (coll) begin
                m_hit = obst;
                if (FLASH) begin m_mode = 2; m_el = 0; end
                else go_over();
            end else if (score_tick) m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
        end else begin
            if (m_el == FC - 1) go_over();
            else m_el++;
        end
        m_startq = start;
        @(posedge clk); #1;
        check("state", state, m_mode);
        check("run", run, m_mode == 1);
        check("score", score, m_score);
        check("hi_score", hi_score, m_hi);
        check("hit_vec", hit_vec, m_hit);
        check("rgb", rgb, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_mode = 0; m_score = 0; m_hi = 0; m_hit = 0; m_el = 0; m_startq = 1;
        check("rst_state", state, 0);
        check("rst_run", run, 0);
        check("rst_score", score, 0);
        check("rst_hi", hi_score, 0);
        check("rst_hit", hit_vec, 0);
        check("rst_rgb", rgb, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic restart();
        start = 1; step();
        start = 0; step();
    endtask

    task automatic ticks(input int n);
        score_tick = 1;
        repeat (n) step();
        score_tick = 0;
    endtask

    task automatic collide_settle();
        goose = 1; obst = 2'b01; step();
        goose = 0; obst = 0;
        repeat (FLASH ? FC : 0) step();
    endtask

    initial begin
        rst_n = 1'b0;
        goose_rgb = 12'h123; obst_rgb = {12'h456, 12'h789};
        score_rgb = 12'hABC; hi_rgb = 12'hDEF; sky_rgb = 12'h0F0;
        vt[0]  = {10'b1_0_1_1_1_11_1_1_1, 12'hABC};
        vt[1]  = {10'b1_0_0_1_1_11_1_1_1, 12'hDEF};
        vt[2]  = {10'b1_0_0_0_1_11_1_1_1, 12'h123};
        vt[3]  = {10'b1_0_0_0_0_11_1_1_1, 12'h789};
        vt[4]  = {10'b1_0_0_0_0_10_1_1_1, 12'h456};
        vt[5]  = {10'b1_0_0_0_0_00_1_1_1, 12'h940};
        vt[6]  = {10'b1_0_0_0_0_00_0_1_1, 12'h2A2};
        vt[7]  = {10'b1_0_0_0_0_00_0_0_1, 12'h0F0};
        vt[8]  = {10'b1_0_0_0_0_00_0_0_0, 12'h000};
        vt[9]  = {10'b0_0_1_1_1_11_1_1_1, 12'h000};
        vt[10] = {10'b1_1_0_0_0_00_0_0_0, 12'h000};
        vt[11] = {10'b1_1_0_0_1_00_0_0_0, 12'h123};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            {video_on, end_px, score_px, hi_px, goose, obst, flr, grass, sky} = vt[i][21:12];
            step();
            check($sformatf("pix%0d", i), rgb, vt[i].exp);
        end
        {video_on, end_px, score_px, hi_px, goose, obst, flr, grass, sky} = '0;
        start = 1;
        do_reset();
        repeat (10) step();
        check("held_idle", state, 0);
        start = 0; step();
        start = 1; step();
        check("start_state", state, 1);
        check("start_run", run, 1);
        check("start_score", score, 0);
        start = 0; step();
        start = 1; step();
        check("run_restart_ignored", state, 1);
        start = 0;
        ticks(5);
        goose = 1; obst = 2'b10; score_tick = 1; step();
        goose = 0; obst = 0; score_tick = 0;
        check("coll_score", score, 5);
        check("coll_hit", hit_vec, 2'b10);
`ifdef GAME_CTRL_FLASH_EN
        check("hit_state", state, 2);
        start = 1; step(); start = 0;
        repeat (FC - 2) step();
        check("hit_len", state, 2);
        video_on = 1; goose = 1; step();
        check("flash_end", state, 3);
        goose = 0;
`else
        check("direct_over", state, 3);
`endif
        check("hi5", hi_score, 5);
        video_on = 1; end_px = 1; step();
        check("end_px_over", rgb, 12'hFFF);
        video_on = 0; end_px = 0;
        restart(); ticks(3); collide_settle();
        check("hi_kept", hi_score, 5);
        restart(); ticks(9); collide_settle();
        check("hi_new", hi_score, 9);
        restart(); ticks(20);
        check("sat4", score4, 15);
        check("score20", score, 20);
        goose = 1; obst = 2'b11; step();
        check("coll_both", hit_vec, 2'b11);
        goose = 0; obst = 0;
        for (int c = 0; c < 2500; c++) begin
            video_on = $urandom_range(0, 3) != 0;
            start = $urandom_range(0, 7) == 0;
            score_tick = $urandom_range(0, 1) == 1;
            goose = $urandom_range(0, 7) == 0;
            obst = 2'($urandom);
            score_px = $urandom_range(0, 7) == 0;
            hi_px = $urandom_range(0, 7) == 0;
            end_px = $urandom_range(0, 3) == 0;
            {flr, grass, sky} = 3'($urandom);
            goose_rgb = 12'($urandom); obst_rgb = 24'($urandom);
            score_rgb = 12'($urandom); hi_rgb = 12'($urandom); sky_rgb = 12'($urandom);
            step();
        end
        start = 0; goose = 0; obst = 0; score_tick = 0;
        restart(); ticks(2);
        do_reset();
        step();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
